// File: rtl/branch_status_table_2way.sv
// Two-way set-associative branch status table.
// Each way stores a full-PC tag, a saturating direction counter and a target.
// A lookup is registered, so results appear one cycle after lookup_pc is sampled.
// Lookup reads state from before the same edge's update.
// Valid bits and LRU bits are the only table state with a reset.
module branch_status_table_2way #(
  parameter int SETS  = 1024,
  parameter int PC_W  = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             hit,
  output logic [CNT_W-1:0] status,
  output logic [PC_W-1:0]  PC_predict_o,
  input  logic             en_1,
  input  logic [PC_W-1:0]  PC_update,
  input  logic             taken_update,
  input  logic [PC_W-1:0]  PC_predict_update
);

  localparam int IDX_W = $clog2(SETS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [SETS-1:0]  valid_mem [2];
  logic [SETS-1:0]  lru;
  logic [PC_W-1:0]  tag_mem [2][SETS];
  logic [CNT_W-1:0] cnt_mem [2][SETS];
  logic [PC_W-1:0]  tgt_mem [2][SETS];

  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] u_idx;
  logic             lk_hit0;
  logic             lk_hit1;
  logic             lk_hit;
  logic             lk_way;
  logic             um0;
  logic             um1;
  logic             upd_match;
  logic             upd_way;
  logic             alloc;
  logic             alloc_way;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign u_idx = PC_update[IDX_W+1:2];

  // A way with a zero counter is treated as not present for prediction.
  assign lk_hit0 = valid_mem[0][l_idx] && (tag_mem[0][l_idx] == lookup_pc)
                   && (cnt_mem[0][l_idx] != '0);
  assign lk_hit1 = valid_mem[1][l_idx] && (tag_mem[1][l_idx] == lookup_pc)
                   && (cnt_mem[1][l_idx] != '0);
  assign lk_hit  = lk_hit0 || lk_hit1;
  assign lk_way  = !lk_hit0;

  // The update match ignores the counter value.
  // A decayed entry is still found, so it is never allocated a second time.
  assign um0       = en_1 && valid_mem[0][u_idx] && (tag_mem[0][u_idx] == PC_update);
  assign um1       = en_1 && valid_mem[1][u_idx] && (tag_mem[1][u_idx] == PC_update);
  assign upd_match = um0 || um1;
  assign upd_way   = !um0;
  assign alloc     = en_1 && !upd_match && taken_update;
  assign alloc_way = !valid_mem[0][u_idx] ? 1'b0 :
                     !valid_mem[1][u_idx] ? 1'b1 : lru[u_idx];

  assign cnt_cur = cnt_mem[upd_way][u_idx];

  // Saturating increment on taken, saturating decrement on not taken.
  always_comb begin
    cnt_next = cnt_cur;
    if (taken_update) begin
      if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - CNT_W'(1);
    end
  end

  // Registered lookup result; a miss or a flush drives all outputs to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit          <= 1'b0;
      status       <= '0;
      PC_predict_o <= '0;
    end else if (flush || !lk_hit) begin
      hit          <= 1'b0;
      status       <= '0;
      PC_predict_o <= '0;
    end else begin
      hit          <= 1'b1;
      status       <= cnt_mem[lk_way][l_idx];
      PC_predict_o <= tgt_mem[lk_way][l_idx];
    end
  end

  // Valid and LRU bookkeeping.
  // The update's LRU write comes after the lookup's, so the update wins on a shared set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_mem[0] <= '0;
      valid_mem[1] <= '0;
      lru          <= '0;
    end else if (flush) begin
      valid_mem[0] <= '0;
      valid_mem[1] <= '0;
      lru          <= '0;
    end else begin
      if (lk_hit)
        lru[l_idx] <= !lk_way;
      if (upd_match) begin
        lru[u_idx] <= !upd_way;
      end else if (alloc) begin
        valid_mem[alloc_way][u_idx] <= 1'b1;
        lru[u_idx]                  <= !alloc_way;
      end
    end
  end

  // Payload arrays have no reset; the valid bits guard every read of them.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (upd_match) begin
        cnt_mem[upd_way][u_idx] <= cnt_next;
        if (taken_update)
          tgt_mem[upd_way][u_idx] <= PC_predict_update;
      end else if (alloc) begin
        tag_mem[alloc_way][u_idx] <= PC_update;
        cnt_mem[alloc_way][u_idx] <= CNT_WEAK;
        tgt_mem[alloc_way][u_idx] <= PC_predict_update;
      end
    end
  end

endmodule

// File: doc/branch_status_table_2way.md
BRANCH_STATUS_TABLE_2WAY -- requirements
Module: branch_status_table_2way

Interface
- REQ-001: The block SHALL expose parameter SETS, default 1024, number of sets (power of two, 2..16384).
- REQ-002: The block SHALL expose parameter PC_W, default 32, PC and target width.
- REQ-003: The block SHALL expose parameter CNT_W, default 2, saturating status counter width (2..4).
- REQ-004: The block SHALL derive IDX_W = log2(SETS) internally; it SHALL NOT be a port or user parameter.
- REQ-005: clk  in  1  single clock; every flop SHALL be rising-edge triggered.
- REQ-006: rst  in  1  reset, asynchronous and active-high.
- REQ-007: flush  in  1  synchronous invalidate-all.
- REQ-008: lookup_pc  in  PC_W  fetch PC to predict.
- REQ-009: hit  out  1  registered lookup hit.
- REQ-010: status  out  CNT_W  registered counter of the hitting way.
- REQ-011: PC_predict_o  out  PC_W  registered stored target of the hitting way.
- REQ-012: en_1  in  1  update strobe.
- REQ-013: PC_update  in  PC_W  resolved branch PC.
- REQ-014: taken_update  in  1  resolved direction.
- REQ-015: PC_predict_update  in  PC_W  resolved target.

Function
- REQ-016: Set index SHALL be PC bits [IDX_W+1:2] (0-based); the full PC SHALL be stored as tag.
- REQ-017: Each set SHALL hold 2 ways (valid, tag, CNT_W counter, target each) plus 1 LRU bit naming the way to replace next.
- REQ-018: Lookup SHALL have 1-cycle latency: outputs at edge N+1 reflect lookup_pc sampled at edge N.
- REQ-019: A way SHALL hit when valid=1, tag==lookup_pc, and counter!=0.
- REQ-020: On a hit, status and PC_predict_o SHALL carry that way's counter and target.
- REQ-021: On a miss, hit, status and PC_predict_o SHALL all be 0.
- REQ-022: A valid lookup hit SHALL set the set's LRU bit to the other way.
- REQ-023: An update-tag match SHALL exist when en_1=1 and PC_update matches a valid way's tag.
- REQ-024: On an update-tag match, the counter SHALL increment if taken_update=1 and decrement otherwise, saturating at 2^CNT_W-1 and at 0.
- REQ-025: On an update-tag match, the target SHALL be overwritten with PC_predict_update only when taken_update=1.
- REQ-026: On an update-tag match, LRU SHALL point to the other way.
- REQ-027: An update miss with taken_update=1 SHALL allocate an invalid way if one exists (way 0 preferred), else the LRU way.
- REQ-028: An allocated way SHALL be written with valid=1, tag=PC_update, counter=2^(CNT_W-1) (weakly taken), target=PC_predict_update.
- REQ-029: After an allocation, LRU SHALL point to the other way.
- REQ-030: An update miss with taken_update=0 SHALL change no state.
- REQ-031: Same-edge lookup and update to one entry SHALL be read-before-write: lookup returns pre-update contents.
- REQ-032: When lookup and update touch the same set in one cycle, the update's LRU write SHALL win.
- REQ-033: Two valid ways with equal tags SHALL never arise; allocation SHALL occur only on an update miss.
- REQ-034: flush=1 SHALL clear all valid and LRU bits at the edge, ignore a same-cycle update, and force hit/status/PC_predict_o to 0 next cycle.
- REQ-035: Counter and target arrays need no reset; valid bits SHALL gate all use of them.

Reset
- REQ-036: rst=1 SHALL immediately, without a clock, clear hit, status, PC_predict_o, all valid bits and all LRU bits.
- REQ-037: Reset asserted mid-update SHALL discard that update.
- REQ-038: The first lookup after rst deasserts SHALL return miss.

Verification
- REQ-039: Reset then lookup 0x100 -> hit=0, status=0, PC_predict_o=0.
- REQ-040: Update 0x100 taken target 0x200, then lookup 0x100 -> next cycle hit=1, status=2, PC_predict_o=0x200; three more taken updates -> status saturates at 3.
- REQ-041: Four not-taken updates on 0x100 -> status 0, then lookup -> hit=0; a further not-taken update changes nothing.
- REQ-042: SETS=1024: allocate 0x1000, 0x2000 (same set); lookup 0x1000; allocate 0x3000 -> 0x2000 evicted, 0x1000 and 0x3000 hit.
- REQ-043: Same-edge lookup and taken update of resident 0x100 (status 2) -> lookup shows 2, next lookup shows 3.
- REQ-044: Assert flush with a concurrent taken update to 0x400 -> all subsequent lookups miss, including 0x400.
